// File: rtl/float_to_fixed_pipe.sv
// float_to_fixed_pipe: 3-stage IEEE-754 float to two's-complement fixed-point
// converter with valid/ready handshake, saturation and status flags.
// Optional build macro: F2FX_ROUND_NEAREST_EN (round to nearest, ties to even;
// default build truncates toward zero).
module float_to_fixed_pipe #(
    parameter int unsigned EW  = 8,
    parameter int unsigned MW  = 23,
    parameter int unsigned FXW = 32,
    parameter int unsigned FRW = 29
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [EW+MW:0]   FLOAT,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [FXW-1:0]   FIXED,
    output logic             OVF,
    output logic             UNF,
    output logic             NAN_INF
);

    localparam int unsigned BIAS = 2**(EW-1) - 1;
    localparam int unsigned FW   = EW + MW + 1;
    localparam int unsigned SHW  = EW + 2;
    localparam int unsigned MAGW = FXW + 1;
    localparam int unsigned WW   = MW + 1 + MAGW;
    localparam int unsigned RW   = 2*MW + 3;
    localparam int          SH_OFS = int'(FRW) - int'(MW) - int'(BIAS);
    localparam logic [MAGW:0] NEG_LIM = {{(MAGW+1-FXW){1'b0}}, 1'b1, {(FXW-1){1'b0}}};
    localparam logic [MAGW:0] POS_LIM = NEG_LIM - (MAGW+1)'(1);
    localparam logic [FXW-1:0] SAT_POS = {1'b0, {(FXW-1){1'b1}}};
    localparam logic [FXW-1:0] SAT_NEG = {1'b1, {(FXW-1){1'b0}}};

    // stage 1 (decode) state
    logic            v1_q, v1_d, sign1_q, sign1_d;
    logic [SHW-1:0]  sh1_q, sh1_d;
    logic [MW:0]     mant1_q, mant1_d;
    logic            nan1_q, nan1_d, inf1_q, inf1_d, den1_q, den1_d;
    // stage 2 (align) state
    logic            v2_q, v2_d, sign2_q, sign2_d;
    logic [MAGW-1:0] mag2_q, mag2_d;
    logic            g2_q, g2_d, s2_q, s2_d, big2_q, big2_d;
    logic            nan2_q, nan2_d, inf2_q, inf2_d, den2_q, den2_d;
    // stage 3 (output) state
    logic            v3_q, v3_d;
    logic [FXW-1:0]  fixed_q, fixed_d;
    logic            ovf_q, ovf_d, unf_q, unf_d, ni_q, ni_d;

    logic adv1, adv2, adv3;

    // hold chain: a stage moves when it is empty or its successor moves
    assign adv3     = ~v3_q | OUT_READY;
    assign adv2     = ~v2_q | adv3;
    assign adv1     = ~v1_q | adv2;
    assign IN_READY = adv1;

    // decode: split fields, restore hidden bit, flush denormals, compute shift
    always_comb begin
        logic [EW-1:0] exp_in;
        logic [MW-1:0] man_in;
        exp_in  = FLOAT[FW-2:MW];
        man_in  = FLOAT[MW-1:0];
        v1_d    = v1_q;
        sign1_d = sign1_q;
        sh1_d   = sh1_q;
        mant1_d = mant1_q;
        nan1_d  = nan1_q;
        inf1_d  = inf1_q;
        den1_d  = den1_q;
        if (adv1) begin
            v1_d    = IN_VALID;
            sign1_d = FLOAT[FW-1];
            sh1_d   = SHW'({2'b00, exp_in}) + SHW'(SH_OFS);
            mant1_d = (exp_in == '0) ? '0 : {1'b1, man_in};
            nan1_d  = (exp_in == '1) & (man_in != '0);
            inf1_d  = (exp_in == '1) & (man_in == '0);
            den1_d  = (exp_in == '0) & (man_in != '0);
        end
    end

    // align: shift to the fixed binary point, keep guard/sticky, flag overflow
    always_comb begin
        logic [SHW-1:0] rs;
        logic [RW-1:0]  ext;
        logic [WW-1:0]  wide;
        logic           huge, g, s;
        rs   = '0;
        ext  = '0;
        wide = '0;
        huge = 1'b0;
        g    = 1'b0;
        s    = 1'b0;
        if (!sh1_q[SHW-1]) begin
            if (sh1_q > SHW'(MAGW-1)) huge = |mant1_q;
            else                      wide = WW'(mant1_q) << sh1_q;
        end else begin
            rs = ~sh1_q + SHW'(1);
            if (rs >= SHW'(MW+2)) begin
                s = |mant1_q;
            end else begin
                ext  = {mant1_q, {(MW+2){1'b0}}} >> rs;
                wide = WW'(ext[RW-1:MW+2]);
                g    = ext[MW+1];
                s    = |ext[MW:0];
            end
        end
        v2_d    = v2_q;
        sign2_d = sign2_q;
        mag2_d  = mag2_q;
        g2_d    = g2_q;
        s2_d    = s2_q;
        big2_d  = big2_q;
        nan2_d  = nan2_q;
        inf2_d  = inf2_q;
        den2_d  = den2_q;
        if (adv2) begin
            v2_d    = v1_q;
            sign2_d = sign1_q;
            mag2_d  = wide[MAGW-1:0];
            g2_d    = g;
            s2_d    = s;
            big2_d  = huge | (|wide[WW-1:MAGW]);
            nan2_d  = nan1_q;
            inf2_d  = inf1_q;
            den2_d  = den1_q;
        end
    end

    // finish: round, saturate against the sign's limit, negate, set flags
    always_comb begin
        logic [MAGW:0]  mag_r;
        logic [FXW-1:0] m;
        logic           inc, ovf_mag;
`ifdef F2FX_ROUND_NEAREST_EN
        inc = g2_q & (s2_q | mag2_q[0]);
`else
        inc = 1'b0;
`endif
        mag_r   = {1'b0, mag2_q} + (MAGW+1)'(inc);
        m       = mag_r[FXW-1:0];
        ovf_mag = big2_q | (sign2_q ? (mag_r > NEG_LIM) : (mag_r > POS_LIM));
        v3_d    = v3_q;
        fixed_d = fixed_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        ni_d    = ni_q;
        if (adv3) begin
            v3_d    = v2_q;
            fixed_d = sign2_q ? (~m + FXW'(1)) : m;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
            ni_d    = 1'b0;
            if (nan2_q) begin
                fixed_d = '0;
                ni_d    = 1'b1;
            end else if (inf2_q || ovf_mag) begin
                fixed_d = sign2_q ? SAT_NEG : SAT_POS;
                ovf_d   = 1'b1;
                ni_d    = inf2_q;
            end else begin
                unf_d   = (mag_r == '0) & (g2_q | s2_q | den2_q);
            end
        end
    end

    // pipeline registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            v1_q <= 1'b0; sign1_q <= 1'b0; sh1_q <= '0; mant1_q <= '0;
            nan1_q <= 1'b0; inf1_q <= 1'b0; den1_q <= 1'b0;
            v2_q <= 1'b0; sign2_q <= 1'b0; mag2_q <= '0; g2_q <= 1'b0;
            s2_q <= 1'b0; big2_q <= 1'b0; nan2_q <= 1'b0; inf2_q <= 1'b0;
            den2_q <= 1'b0;
            v3_q <= 1'b0; fixed_q <= '0; ovf_q <= 1'b0; unf_q <= 1'b0;
            ni_q <= 1'b0;
        end else begin
            v1_q <= v1_d; sign1_q <= sign1_d; sh1_q <= sh1_d; mant1_q <= mant1_d;
            nan1_q <= nan1_d; inf1_q <= inf1_d; den1_q <= den1_d;
            v2_q <= v2_d; sign2_q <= sign2_d; mag2_q <= mag2_d; g2_q <= g2_d;
            s2_q <= s2_d; big2_q <= big2_d; nan2_q <= nan2_d; inf2_q <= inf2_d;
            den2_q <= den2_d;
            v3_q <= v3_d; fixed_q <= fixed_d; ovf_q <= ovf_d; unf_q <= unf_d;
            ni_q <= ni_d;
        end
    end

    assign OUT_VALID = v3_q;
    assign FIXED     = fixed_q;
    assign OVF       = ovf_q;
    assign UNF       = unf_q;
    assign NAN_INF   = ni_q;

endmodule

// File: tb/tb_float_to_fixed_pipe.sv
// Directed and random-stream bench for float_to_fixed_pipe (default parameters).
// Expected values honour F2FX_ROUND_NEAREST_EN when it is defined.
module tb_float_to_fixed_pipe;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] FLOAT;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] FIXED;
    logic        OVF, UNF, NAN_INF;

    int errors = 0;
    int checks = 0;

    float_to_fixed_pipe dut (
        .CLK(CLK), .RST(RST),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .FLOAT(FLOAT),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .FIXED(FIXED), .OVF(OVF), .UNF(UNF), .NAN_INF(NAN_INF)
    );

    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // reference: exact value scaled by 2^64 extra fraction bits, returns {fixed, ovf, unf, nan_inf}
    function automatic logic [34:0] ref_model(input logic [31:0] f);
        logic         s;
        logic [7:0]   e;
        logic [22:0]  m;
        logic [255:0] val;
        logic [191:0] intp;
        logic [63:0]  frac;
        logic [31:0]  mag;
        int           shift;
        s = f[31]; e = f[30:23]; m = f[22:0];
        if (e == 8'hFF) begin
            if (m != 0) return {32'h0, 3'b001};
            return {(s ? 32'h80000000 : 32'h7FFFFFFF), 3'b101};
        end
        if (e == 0) return (m == 0) ? 35'h0 : {32'h0, 3'b010};
        shift = int'(e) - 57;
        if (shift < 0) return {32'h0, 3'b010};
        val  = 256'({1'b1, m}) << shift;
        intp = val[255:64];
        frac = val[63:0];
`ifdef F2FX_ROUND_NEAREST_EN
        if (frac[63] && ((|frac[62:0]) || intp[0])) intp = intp + 192'd1;
`endif
        if (s ? (intp > 192'h80000000) : (intp > 192'h7FFFFFFF))
            return {(s ? 32'h80000000 : 32'h7FFFFFFF), 3'b100};
        mag = intp[31:0];
        return {(s ? (32'h0 - mag) : mag), 1'b0, (intp == 0), 1'b0};
    endfunction

    function automatic logic [31:0] rand_float();
        logic [7:0] e;
        int         k;
        k = int'($urandom_range(0, 15));
        if (k == 0)      e = 8'hFF;
        else if (k == 1) e = 8'h00;
        else             e = 8'(70 + $urandom_range(0, 80));
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    // send one sample with an always-ready sink; report output and edges from accept
    task automatic run_one(input logic [31:0] f, output logic [31:0] fx,
                           output logic [2:0] fl, output int lat);
        int w;
        @(negedge CLK);
        FLOAT = f; IN_VALID = 1'b1; OUT_READY = 1'b1;
        #1;
        w = 0;
        while (!IN_READY && w < 20) begin @(negedge CLK); #1; w++; end
        @(posedge CLK);
        lat = 1;
        #1 IN_VALID = 1'b0;
        while (!OUT_VALID && lat < 20) begin @(posedge CLK); lat++; #1; end
        fx = FIXED;
        fl = {OVF, UNF, NAN_INF};
    endtask

    task automatic test_reset();
        RST = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0; FLOAT = '0;
        repeat (3) @(posedge CLK);
        #1;
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", OUT_VALID); end
        checks++; if (FIXED !== 32'h0) begin errors++; $display("FAIL reset_fixed: got %h want 00000000", FIXED); end
        checks++; if ({OVF, UNF, NAN_INF} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {OVF, UNF, NAN_INF}); end
        @(negedge CLK); RST = 1'b1;
        #1;
        checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", IN_READY); end
    endtask

    task automatic test_directed();
        logic [31:0] vin [13] = '{32'h3F800000, 32'hBFC00000, 32'hC0800000, 32'h40800000,
                                  32'h7F800000, 32'h7FC00000, 32'h80000000, 32'hFF800000,
                                  32'h407FFFFF, 32'h00000001, 32'h31000000, 32'h3F000000,
                                  32'hC0800001};
        logic [31:0] vfx [13] = '{32'h20000000, 32'hD0000000, 32'h80000000, 32'h7FFFFFFF,
                                  32'h7FFFFFFF, 32'h00000000, 32'h00000000, 32'h80000000,
                                  32'h7FFFFF80, 32'h00000000, 32'h00000001, 32'h10000000,
                                  32'h80000000};
        logic [2:0]  vfl [13] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b101, 3'b001, 3'b000,
                                  3'b101, 3'b000, 3'b010, 3'b000, 3'b000, 3'b100};
        logic [31:0] fx;
        logic [2:0]  fl;
        int          lat;
        for (int i = 0; i < 13; i++) begin
            run_one(vin[i], fx, fl, lat);
            checks++; if (lat != 3) begin errors++; $display("FAIL latency[%h]: got %0d want 3", vin[i], lat); end
            checks++; if (fx !== vfx[i]) begin errors++; $display("FAIL fixed[%h]: got %h want %h", vin[i], fx, vfx[i]); end
            checks++; if (fl !== vfl[i]) begin errors++; $display("FAIL flags[%h]: got %b want %b", vin[i], fl, vfl[i]); end
        end
    endtask

    task automatic test_rounding();
        logic [31:0] vin [5] = '{32'h30C00000, 32'h30800000, 32'h31400000, 32'h31A00000, 32'hB0C00000};
`ifdef F2FX_ROUND_NEAREST_EN
        logic [31:0] vfx [5] = '{32'h00000001, 32'h00000000, 32'h00000002, 32'h00000002, 32'hFFFFFFFF};
        logic [2:0]  vfl [5] = '{3'b000, 3'b010, 3'b000, 3'b000, 3'b000};
`else
        logic [31:0] vfx [5] = '{32'h00000000, 32'h00000000, 32'h00000001, 32'h00000002, 32'h00000000};
        logic [2:0]  vfl [5] = '{3'b010, 3'b010, 3'b000, 3'b000, 3'b010};
`endif
        logic [31:0] fx;
        logic [2:0]  fl;
        int          lat;
        for (int i = 0; i < 5; i++) begin
            run_one(vin[i], fx, fl, lat);
            checks++; if (fx !== vfx[i]) begin errors++; $display("FAIL round_fixed[%h]: got %h want %h", vin[i], fx, vfx[i]); end
            checks++; if (fl !== vfl[i]) begin errors++; $display("FAIL round_flags[%h]: got %b want %b", vin[i], fl, vfl[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vin [4] = '{32'h3F800000, 32'hBFC00000, 32'h40000000, 32'h3F000000};
        logic [31:0] vfx [4] = '{32'h20000000, 32'hD0000000, 32'h40000000, 32'h10000000};
        int k = 0;
        int first = -1;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            OUT_READY = 1'b1;
            IN_VALID  = (c < 4);
            if (c < 4) FLOAT = vin[c];
            #1;
            if (c < 4) begin
                checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", c, IN_READY); end
            end
            @(posedge CLK);
            #1;
            if (OUT_VALID) begin
                if (first < 0) first = c;
                checks++;
                if (k >= 4) begin errors++; $display("FAIL b2b_extra: got output %h want none", FIXED); end
                else if (FIXED !== vfx[k] || (c - first) != k) begin
                    errors++; $display("FAIL b2b_out[%0d]: got %h at cycle %0d want %h at cycle %0d", k, FIXED, c, vfx[k], first + k);
                end
                k++;
            end
        end
        IN_VALID = 1'b0;
        checks++; if (first != 2 || k != 4) begin errors++; $display("FAIL b2b_timing: got first=%0d count=%0d want first=2 count=4", first, k); end
    endtask

    task automatic test_stream();
        logic [34:0] expq [$];
        logic [34:0] held, e, got_v;
        logic        held_v = 1'b0, in_x = 1'b0;
        int          sent = 0, got = 0, cyc = 0;
        while (got < 64 && cyc < 3000) begin
            @(negedge CLK);
            cyc++;
            if (in_x || !IN_VALID) begin
                if (sent < 64 && $urandom_range(0, 3) != 0) begin
                    IN_VALID = 1'b1; FLOAT = rand_float();
                end else begin
                    IN_VALID = 1'b0;
                end
            end
            OUT_READY = ($urandom_range(0, 3) != 0);
            #1;
            got_v = {FIXED, OVF, UNF, NAN_INF};
            if (held_v) begin
                checks++;
                if (!OUT_VALID || got_v !== held) begin
                    errors++; $display("FAIL stall_stable: got v=%b %h want v=1 %h", OUT_VALID, got_v, held);
                end
            end
            in_x = IN_VALID & IN_READY;
            if (in_x) begin expq.push_back(ref_model(FLOAT)); sent++; end
            if (OUT_VALID && OUT_READY) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++; $display("FAIL stream_dup: got %h with nothing outstanding", got_v);
                end else begin
                    e = expq.pop_front();
                    if (got_v !== e) begin errors++; $display("FAIL stream_out[%0d]: got %h want %h", got, got_v, e); end
                end
                got++;
            end
            held_v = OUT_VALID & ~OUT_READY;
            held   = got_v;
        end
        @(negedge CLK); IN_VALID = 1'b0;
        checks++;
        if (got != 64 || sent != 64 || expq.size() != 0) begin
            errors++; $display("FAIL stream_count: got sent=%0d recv=%0d pending=%0d want 64/64/0", sent, got, expq.size());
        end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] vin [3] = '{32'h3F800000, 32'hBFC00000, 32'h40000000};
        logic [31:0] fx;
        logic [2:0]  fl;
        int          lat, seen;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            OUT_READY = 1'b0; IN_VALID = 1'b1; FLOAT = vin[i];
            @(posedge CLK);
        end
        @(negedge CLK);
        IN_VALID = 1'b0; RST = 1'b0;
        #1;
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL midrst_async: got OUT_VALID=%b want 0", OUT_VALID); end
        @(posedge CLK); #1;
        checks++; if (OUT_VALID !== 1'b0 || FIXED !== 32'h0) begin errors++; $display("FAIL midrst_edge: got v=%b %h want v=0 00000000", OUT_VALID, FIXED); end
        @(negedge CLK); RST = 1'b1; OUT_READY = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin @(posedge CLK); #1; if (OUT_VALID) seen++; end
        checks++; if (seen != 0) begin errors++; $display("FAIL midrst_stale: got %0d outputs want 0", seen); end
        run_one(32'h40000000, fx, fl, lat);
        checks++; if (fx !== 32'h40000000 || fl !== 3'b000 || lat != 3) begin
            errors++; $display("FAIL midrst_first: got %h %b lat=%0d want 40000000 000 lat=3", fx, fl, lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_rounding();
        test_back_to_back();
        test_stream();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
